// File: rtl/axi_freq_selector_loader.sv
// AXI4-Lite master that turns a load/readback command stream into register
// accesses on the frequency-selector block (index, random-read addr, random-read data).
module axi_freq_selector_loader #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 5,
   parameter int BASE_ADDR          = 0,
   parameter int TIMEOUT_CYCLES     = 1023
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESETN,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_op,
   input  logic [13:0]                     cmd_data,
   output logic                            rsp_valid,
   output logic [13:0]                     rsp_data,
   output logic                            rsp_err,
   output logic [7:0]                      load_count,
   output logic                            timeout_flag,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int AW  = C_M_AXI_ADDR_WIDTH;
   localparam int DW  = C_M_AXI_DATA_WIDTH;
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW-1:0]  ADDR_IDX = AW'(BASE_ADDR);
   localparam logic [AW-1:0]  ADDR_RAD = ADDR_IDX + AW'(4);
   localparam logic [AW-1:0]  ADDR_RDD = ADDR_IDX + AW'(8);
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_DONE} state_t;

   state_t         state, state_next;
   logic           op;
   logic [WDW-1:0] wd_cnt;
   logic           accept, waiting, unused_rdata;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_WSTRB  = '1;
   assign accept       = cmd_valid && cmd_ready;
   assign waiting      = (state == S_WR) || (state == S_WRESP) ||
                         (state == S_RD) || (state == S_RDATA);
   assign unused_rdata = ^M_AXI_RDATA[DW-1:14];

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) state <= S_IDLE;
      else                state <= state_next;
   end

   always_comb begin
      state_next   = state;
      cmd_ready    = 1'b0;
      M_AXI_BREADY = 1'b0;
      M_AXI_RREADY = 1'b0;
      rsp_valid    = 1'b0;
      case (state)
         S_IDLE: begin
            // gated by reset so the ready output is low while reset is held
            cmd_ready = M_AXI_ARESETN;
            if (cmd_valid) state_next = S_WR;
         end
         S_WR: begin
            if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY))
               state_next = S_WRESP;
         end
         S_WRESP: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) state_next = op ? S_RD : S_DONE;
         end
         S_RD: begin
            if (M_AXI_ARREADY) state_next = S_RDATA;
         end
         S_RDATA: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) state_next = S_DONE;
         end
         S_DONE: begin
            rsp_valid  = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         op            <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_ARADDR  <= '0;
         M_AXI_WDATA   <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         load_count    <= '0;
      end else begin
         if (accept) begin
            op            <= cmd_op;
            rsp_err       <= 1'b0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_AWADDR  <= cmd_op ? ADDR_RAD : ADDR_IDX;
            M_AXI_WDATA   <= cmd_op ? {{(DW-7){1'b0}}, cmd_data[6:0]}
                                    : {{(DW-14){1'b0}}, cmd_data};
            if (cmd_op) M_AXI_ARADDR <= ADDR_RDD;
         end
         // AW and W retire independently; the slave may take them in either order
         if (state == S_WR) begin
            if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
         end
         if (state == S_WRESP && M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) rsp_err <= 1'b1;
            if (op) M_AXI_ARVALID <= 1'b1;
            else    rsp_data      <= '0;
         end
         if (state == S_RD && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
         if (state == S_RDATA && M_AXI_RVALID) begin
            rsp_data <= M_AXI_RDATA[13:0];
            if (M_AXI_RRESP != 2'b00) rsp_err <= 1'b1;
         end
         if (state == S_DONE && !op) load_count <= load_count + 8'd1;
      end
   end

   // Watchdog only flags a stall; VALID can never be withdrawn once raised.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         wd_cnt       <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (state_next != state)                wd_cnt <= '0;
         else if (waiting && wd_cnt != WD_MAX)   wd_cnt <= wd_cnt + 1'b1;
         if (waiting && state_next == state && wd_cnt == WD_LAST) timeout_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_freq_selector_loader.sv
// Bench for axi_freq_selector_loader: directed vector table, randomized commands
// against a command-level model, and hand sequences for timeout, wrap and reset.
module tb_axi_freq_selector_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_op;
   logic [13:0] cmd_data;
   logic        rsp_valid, rsp_err, timeout_flag;
   logic [13:0] rsp_data;
   logic [7:0]  load_count;
   logic [4:0]  M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   axi_freq_selector_loader #(
      .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(5), .BASE_ADDR(0), .TIMEOUT_CYCLES(15)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .load_count(load_count), .timeout_flag(timeout_flag),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [13:0] data;
      int          aw_dly, w_dly, b_dly, ar_dly;
      logic [1:0]  bresp, rresp;
      logic [31:0] rdata;
      logic [13:0] exp_data;
      logic        exp_err;
   } vec_t;

   int errs = 0, checks = 0;
   int lc_model = 0;
   int aw_hs = 0, w_hs = 0, rsp_cnt = 0;
   vec_t tbl [7];

   // handshake monitors: exactly one AW and one W per command
   always @(posedge clk) begin
      if (rst_n && M_AXI_AWVALID && M_AXI_AWREADY) aw_hs++;
      if (rst_n && M_AXI_WVALID && M_AXI_WREADY)   w_hs++;
      if (rst_n && rsp_valid)                      rsp_cnt++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_data = v.op ? v.rdata[13:0] : 14'd0;
      r.exp_err  = (v.bresp != 2'b00) || (v.op && v.rresp != 2'b00);
      return r;
   endfunction

   task automatic aw_slave(input int dly, output logic [31:0] addr);
      int g = 0;
      while (M_AXI_AWVALID !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      chk("aw_valid_seen", M_AXI_AWVALID, 1);
      addr = {27'd0, M_AXI_AWADDR};
      if (M_AXI_AWVALID !== 1'b1) return;
      repeat (dly) begin
         @(negedge clk);
         chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, addr[4:0]});
      end
      M_AXI_AWREADY = 1'b1;
      @(negedge clk);
      M_AXI_AWREADY = 1'b0;
      chk("aw_drop", M_AXI_AWVALID, 0);
   endtask

   task automatic w_slave(input int dly, output logic [31:0] data);
      int g = 0;
      while (M_AXI_WVALID !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      chk("w_valid_seen", M_AXI_WVALID, 1);
      chk("wstrb", M_AXI_WSTRB, 4'hF);
      chk("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
      data = M_AXI_WDATA;
      if (M_AXI_WVALID !== 1'b1) return;
      repeat (dly) begin
         @(negedge clk);
         chk("w_hold", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, data});
      end
      M_AXI_WREADY = 1'b1;
      @(negedge clk);
      M_AXI_WREADY = 1'b0;
      chk("w_drop", M_AXI_WVALID, 0);
   endtask

   task automatic do_cmd(input vec_t v);
      int g = 0;
      int aw0 = aw_hs, w0 = w_hs;
      logic [31:0] a, w;
      cmd_op = v.op; cmd_data = v.data; cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      chk("cmd_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("err_clear", rsp_err, 0);
      chk("busy", cmd_ready, 0);
      fork
         aw_slave(v.aw_dly, a);
         w_slave(v.w_dly, w);
      join
      chk("awaddr", a, v.op ? 32'h4 : 32'h0);
      chk("wdata", w, v.op ? {25'd0, v.data[6:0]} : {18'd0, v.data});
      repeat (v.b_dly) @(negedge clk);
      chk("bready", M_AXI_BREADY, 1);
      M_AXI_BVALID = 1'b1; M_AXI_BRESP = v.bresp;
      @(negedge clk);
      M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
      if (v.op) begin
         g = 0;
         while (M_AXI_ARVALID !== 1'b1 && g < 50) begin @(negedge clk); g++; end
         chk("ar_valid_seen", M_AXI_ARVALID, 1);
         chk("araddr", M_AXI_ARADDR, 5'h08);
         repeat (v.ar_dly) begin
            @(negedge clk);
            chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 5'h08});
         end
         M_AXI_ARREADY = 1'b1;
         @(negedge clk);
         M_AXI_ARREADY = 1'b0;
         chk("ar_drop", M_AXI_ARVALID, 0);
         chk("rready", M_AXI_RREADY, 1);
         M_AXI_RVALID = 1'b1; M_AXI_RDATA = v.rdata; M_AXI_RRESP = v.rresp;
         @(negedge clk);
         M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00;
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, v.exp_data);
      chk("rsp_err", rsp_err, v.exp_err);
      if (!v.op) lc_model = (lc_model + 1) % 256;
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
      chk("load_count", load_count, lc_model);
      chk("rsp_hold", {rsp_err, rsp_data}, {v.exp_err, v.exp_data});
      chk("ready_back", cmd_ready, 1);
      chk("one_write", {aw_hs - aw0, w_hs - w0}, {32'd1, 32'd1});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lc_model = 0;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk(nm, {cmd_ready, rsp_valid, rsp_err, rsp_data, load_count, timeout_flag,
               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
               M_AXI_AWADDR, M_AXI_ARADDR}, 64'd0);
      chk({nm, "_wdata"}, M_AXI_WDATA, 0);
   endtask

   initial begin
      vec_t v;
      logic [31:0] a, w;
      int rc;
      // op data aw w b ar bresp rresp rdata exp_data exp_err
      tbl[0] = '{1'b0, 14'h1ABC, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        14'h0000, 1'b0};
      tbl[1] = '{1'b0, 14'h0155, 0, 3, 1, 0, 2'b00, 2'b00, 32'h0,        14'h0000, 1'b0};
      tbl[2] = '{1'b1, 14'h0005, 0, 0, 0, 6, 2'b00, 2'b00, 32'h00002345, 14'h2345, 1'b0};
      tbl[3] = '{1'b0, 14'h3FFF, 1, 1, 0, 0, 2'b10, 2'b00, 32'h0,        14'h0000, 1'b1};
      tbl[4] = '{1'b1, 14'h3FFF, 2, 0, 0, 1, 2'b00, 2'b10, 32'hFFFFC001, 14'h0001, 1'b1};
      tbl[5] = '{1'b0, 14'h0000, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        14'h0000, 1'b0};
      tbl[6] = '{1'b1, 14'h3F80, 3, 0, 2, 3, 2'b00, 2'b00, 32'h12340ABC, 14'h0ABC, 1'b0};

      rst_n = 1'b0;
      #1;
      chk_reset_outputs("reset_state");
      do_reset();
      chk("idle_ready", cmd_ready, 1);

      for (int i = 0; i < 7; i++) do_cmd(tbl[i]);

      for (int i = 0; i < 60; i++) begin
         v.op     = 1'($urandom_range(0, 1));
         v.data   = 14'($urandom);
         v.aw_dly = $urandom_range(0, 3);
         v.w_dly  = $urandom_range(0, 3);
         v.b_dly  = $urandom_range(0, 3);
         v.ar_dly = $urandom_range(0, 6);
         v.bresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         v.rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         v.rdata  = $urandom;
         do_cmd(model(v));
      end
      chk("no_timeout", timeout_flag, 0);

      // 256 back-to-back loads wrap the counter
      do_reset();
      for (int i = 0; i < 256; i++) begin
         v = '{1'b0, 14'(i), 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 14'h0, 1'b0};
         do_cmd(model(v));
      end
      chk("count_wrap", load_count, 0);

      // reset asserted while waiting in WRESP
      do_reset();
      cmd_op = 1'b0; cmd_data = 14'h0042; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      fork
         aw_slave(0, a);
         w_slave(0, w);
      join
      chk("wresp_bready", M_AXI_BREADY, 1);
      rc = rsp_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lc_model = 0;
      repeat (4) @(negedge clk);
      chk("no_rsp_after_reset", rsp_cnt, rc);
      chk("idle_after_reset", {cmd_ready, load_count}, {1'b1, 8'd0});

      // AWREADY never arrives: watchdog fires, AWVALID stays up
      cmd_op = 1'b0; cmd_data = 14'h0001; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("timeout_early", timeout_flag, 0);
      repeat (10) @(negedge clk);
      chk("timeout_set", timeout_flag, 1);
      chk("awvalid_held", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
      repeat (5) @(negedge clk);
      chk("timeout_sticky", timeout_flag, 1);
      do_reset();
      chk("timeout_cleared", timeout_flag, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
